// File: rtl/regfile_pkg.sv
// Shared types and constants for the regfile writeback arbiter.
package regfile_pkg;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    localparam int REQ_ALU  = 0;
    localparam int REQ_MEM  = 1;
    localparam int REQ_MDU  = 2;
    localparam int REG_ZERO = 0;

    // Cyclic successor of a requester index, wrapping n-1 back to 0.
    function automatic int wrap_next(input int idx, input int n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Cyclic priority search: one-hot grant to the first valid requester at or after rr_ptr.
module rr_pick #(
    parameter int NREQ = 3,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] valid,
    input  logic [PW-1:0]   rr_ptr,
    output logic [NREQ-1:0] grant
);

    logic          found;
    logic [PW-1:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = PW'((int'(rr_ptr) + k) % NREQ);
            if (!found && valid[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter with burst locking onto a single regfile write port.
// Define REGFILE_WB_FWD_EN to add the two combinational write-port forwarding taps.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int DW   = 32,
    parameter int AW   = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    input  logic [NREQ-1:0]      req_ovf,
    input  logic [NREQ-1:0]      req_last,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rf_we,
    output logic [AW-1:0]        rf_waddr,
    output logic [DW-1:0]        rf_wdata,
    output logic                 rf_ovf,
    output logic [15:0]          drop_cnt
`ifdef REGFILE_WB_FWD_EN
    ,
    input  logic [AW-1:0]        fwd_raddr1,
    input  logic [AW-1:0]        fwd_raddr2,
    output logic                 fwd_hit1,
    output logic                 fwd_hit2,
    output logic [DW-1:0]        fwd_data1,
    output logic [DW-1:0]        fwd_data2
`endif
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    if (NREQ < 2 || NREQ > 4) begin : g_bad_nreq
        $error("regfile_wb_arbiter: NREQ must be in 2..4");
    end

    arb_state_t      state;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   owner;
    logic [PW-1:0]   gnt_idx;
    logic [NREQ-1:0] rr_grant;
    logic [NREQ-1:0] owner_onehot;
    logic            fire;
    logic            sel_drop;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_data;
    logic            sel_ovf;
    logic            sel_last;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr_pick (
        .valid  (req_valid),
        .rr_ptr (rr_ptr),
        .grant  (rr_grant)
    );

    // While locked only the burst owner is eligible; reset forces every ready low.
    always_comb begin
        owner_onehot        = '0;
        owner_onehot[owner] = 1'b1;
        if (!rst) begin
            req_ready = '0;
        end else if (state == LOCK) begin
            req_ready = owner_onehot & req_valid;
        end else begin
            req_ready = rr_grant;
        end
    end

    always_comb begin
        gnt_idx  = '0;
        sel_addr = '0;
        sel_data = '0;
        sel_ovf  = 1'b0;
        sel_last = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                gnt_idx  = PW'(i);
                sel_addr = req_addr[i*AW +: AW];
                sel_data = req_data[i*DW +: DW];
                sel_ovf  = req_ovf[i];
                sel_last = req_last[i];
            end
        end
        fire     = |req_ready;
        sel_drop = sel_ovf || (sel_addr == AW'(REG_ZERO));
    end

    // A beat with last=0 opens a burst; the owner's last beat closes it and advances rr_ptr.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ARB;
            rr_ptr   <= '0;
            owner    <= '0;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            rf_ovf   <= 1'b0;
            drop_cnt <= '0;
        end else begin
            rf_we <= 1'b0;
            if (fire) begin
                rf_we    <= !sel_drop;
                rf_waddr <= sel_addr;
                rf_wdata <= sel_data;
                rf_ovf   <= sel_ovf;
                if (sel_drop && (drop_cnt != 16'hFFFF)) begin
                    drop_cnt <= drop_cnt + 16'd1;
                end
                if (sel_last) begin
                    state  <= ARB;
                    rr_ptr <= PW'(wrap_next(int'(gnt_idx), NREQ));
                end else if (state == ARB) begin
                    state <= LOCK;
                    owner <= gnt_idx;
                end
            end
        end
    end

`ifdef REGFILE_WB_FWD_EN
    assign fwd_hit1  = rf_we && (rf_waddr == fwd_raddr1) && (fwd_raddr1 != AW'(REG_ZERO));
    assign fwd_hit2  = rf_we && (rf_waddr == fwd_raddr2) && (fwd_raddr2 != AW'(REG_ZERO));
    assign fwd_data1 = rf_wdata;
    assign fwd_data2 = rf_wdata;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: expected port writes are queued per cycle and compared after the edge.
`timescale 1ns/1ps
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req_valid;
    logic [14:0] req_addr;
    logic [95:0] req_data;
    logic [2:0]  req_ovf;
    logic [2:0]  req_last;
    logic [2:0]  req_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        rf_ovf;
    logic [15:0] drop_cnt;
`ifdef REGFILE_WB_FWD_EN
    logic [4:0]  fwd_raddr1;
    logic [4:0]  fwd_raddr2;
    logic        fwd_hit1;
    logic        fwd_hit2;
    logic [31:0] fwd_data1;
    logic [31:0] fwd_data2;
`endif

    typedef struct packed {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        ovf;
        logic [15:0] drop;
    } exp_t;

    exp_t        sbq[$];
    int          errors = 0;
    int          checks = 0;
    logic [4:0]  heldAddr;
    logic [31:0] heldData;
    logic        heldOvf;
    logic [15:0] expDrop;
    int          sent[3];

    regfile_wb_arbiter #(
        .NREQ (3),
        .DW   (32),
        .AW   (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ovf   (req_ovf),
        .req_last  (req_last),
        .req_ready (req_ready),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .rf_ovf    (rf_ovf),
        .drop_cnt  (drop_cnt)
`ifdef REGFILE_WB_FWD_EN
        ,
        .fwd_raddr1 (fwd_raddr1),
        .fwd_raddr2 (fwd_raddr2),
        .fwd_hit1   (fwd_hit1),
        .fwd_hit2   (fwd_hit2),
        .fwd_data1  (fwd_data1),
        .fwd_data2  (fwd_data2)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int i, input logic v, input logic [4:0] a,
                                 input logic [31:0] d, input logic o, input logic l);
        req_valid[i]       = v;
        req_addr[i*5 +: 5] = a;
        req_data[i*32 +: 32] = d;
        req_ovf[i]         = o;
        req_last[i]        = l;
    endtask

    task automatic modelReset();
        heldAddr = '0;
        heldData = '0;
        heldOvf  = 1'b0;
        expDrop  = '0;
        sbq.delete();
    endtask

    task automatic resetDut();
        @(negedge clk);
        req_valid = '0;
        rst = 1'b0;
        #2;
        rst = 1'b1;
        modelReset();
    endtask

    // Called after the inputs are driven for a cycle: checks ready, queues the expected write, checks it after the edge.
    task automatic runCycle(input string tag, input logic [2:0] expReady);
        exp_t e;
        exp_t got;
        int   g;
        logic [4:0]  a;
        logic [31:0] d;
        logic        o;
        #1;
        checkOutput({tag, "_ready"}, {61'd0, req_ready}, {61'd0, expReady});
        g = -1;
        for (int i = 0; i < 3; i++) if (expReady[i]) g = i;
        if (g >= 0) begin
            a = req_addr[g*5 +: 5];
            d = req_data[g*32 +: 32];
            o = req_ovf[g];
            if ((o || a == 5'd0) && expDrop != 16'hFFFF) expDrop = expDrop + 16'd1;
            e.we = !o && (a != 5'd0);
            heldAddr = a;
            heldData = d;
            heldOvf  = o;
            sent[g]++;
        end else begin
            e.we = 1'b0;
        end
        e.addr = heldAddr;
        e.data = heldData;
        e.ovf  = heldOvf;
        e.drop = expDrop;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        got = sbq.pop_front();
        checkOutput({tag, "_we"},    {63'd0, rf_we},    {63'd0, got.we});
        checkOutput({tag, "_waddr"}, {59'd0, rf_waddr}, {59'd0, got.addr});
        checkOutput({tag, "_wdata"}, {32'd0, rf_wdata}, {32'd0, got.data});
        checkOutput({tag, "_ovf"},   {63'd0, rf_ovf},   {63'd0, got.ovf});
        checkOutput({tag, "_drop"},  {48'd0, drop_cnt}, {48'd0, got.drop});
    endtask

    initial begin
        rst       = 1'b0;
        req_valid = 3'b111;
        req_addr  = {5'd3, 5'd2, 5'd1};
        req_data  = '0;
        req_ovf   = '0;
        req_last  = '1;
`ifdef REGFILE_WB_FWD_EN
        fwd_raddr1 = '0;
        fwd_raddr2 = '0;
`endif
        for (int i = 0; i < 3; i++) sent[i] = 0;
        modelReset();

        // Reset state with every requester valid
        #3;
        checkOutput("rst_ready", {61'd0, req_ready}, 64'd0);
        checkOutput("rst_we",    {63'd0, rf_we},     64'd0);
        checkOutput("rst_waddr", {59'd0, rf_waddr},  64'd0);
        checkOutput("rst_wdata", {32'd0, rf_wdata},  64'd0);
        checkOutput("rst_ovf",   {63'd0, rf_ovf},    64'd0);
        checkOutput("rst_drop",  {48'd0, drop_cnt},  64'd0);

        // Single ALU beat
        @(negedge clk);
        rst = 1'b1;
        req_valid = '0;
        applyStimulus(0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b1);
        runCycle("single", 3'b001);
        @(negedge clk);
        req_valid = '0;
        runCycle("single_idle", 3'b000);

`ifdef REGFILE_WB_FWD_EN
        @(negedge clk);
        applyStimulus(0, 1'b1, 5'd7, 32'h0000_1234, 1'b0, 1'b1);
        runCycle("fwd", 3'b001);
        fwd_raddr1 = 5'd7;
        fwd_raddr2 = 5'd0;
        #1;
        checkOutput("fwd_hit1",  {63'd0, fwd_hit1},  64'd1);
        checkOutput("fwd_data1", {32'd0, fwd_data1}, 64'h0000_1234);
        checkOutput("fwd_hit2",  {63'd0, fwd_hit2},  64'd0);
        @(negedge clk);
        req_valid = '0;
        runCycle("fwd_idle", 3'b000);
`endif

        // Round-robin with all three requesters continuously valid
        resetDut();
        for (int i = 0; i < 3; i++) sent[i] = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++)
                applyStimulus(i, 1'b1, 5'(10 + i), 32'hA000_0000 + 32'(i * 16 + sent[i]), 1'b0, 1'b1);
            runCycle($sformatf("rr%0d", c), 3'b001 << (c % 3));
        end

        // MDU burst locks out the ALU, including a cycle where the owner drops valid
        @(negedge clk);
        req_valid = '0;
        applyStimulus(1, 1'b1, 5'd20, 32'h0000_0020, 1'b0, 1'b1);
        runCycle("pre_mem", 3'b010);
        @(negedge clk);
        req_valid = '0;
        applyStimulus(0, 1'b1, 5'd1, 32'h0000_0011, 1'b0, 1'b1);
        applyStimulus(2, 1'b1, 5'd8, 32'h0000_0088, 1'b0, 1'b0);
        runCycle("burst0", 3'b100);
        @(negedge clk);
        req_valid[2] = 1'b0;
        runCycle("burst_gap", 3'b000);
        @(negedge clk);
        applyStimulus(2, 1'b1, 5'd9, 32'h0000_0099, 1'b0, 1'b1);
        runCycle("burst1", 3'b100);
        @(negedge clk);
        req_valid[2] = 1'b0;
        runCycle("after_burst", 3'b001);

        // Dropped beats: register zero, then overflow
        @(negedge clk);
        req_valid = '0;
        applyStimulus(1, 1'b1, 5'd0, 32'h0000_0055, 1'b0, 1'b1);
        runCycle("drop_zero", 3'b010);
        @(negedge clk);
        req_valid = '0;
        applyStimulus(0, 1'b1, 5'd3, 32'h0000_0033, 1'b1, 1'b1);
        runCycle("drop_ovf", 3'b001);
        checkOutput("drop_total", {48'd0, drop_cnt}, 64'd2);
        @(negedge clk);
        req_valid = '0;
        runCycle("drop_idle", 3'b000);

        // Reset asserted while the MDU holds the lock
        @(negedge clk);
        applyStimulus(2, 1'b1, 5'd12, 32'h0000_000C, 1'b0, 1'b0);
        runCycle("lock_open", 3'b100);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(0, 1'b1, 5'd4, 32'h0000_0044, 1'b0, 1'b1);
        applyStimulus(2, 1'b1, 5'd13, 32'h0000_000D, 1'b0, 1'b1);
        #1;
        checkOutput("midrst_ready", {61'd0, req_ready}, 64'd0);
        checkOutput("midrst_we",    {63'd0, rf_we},     64'd0);
        checkOutput("midrst_waddr", {59'd0, rf_waddr},  64'd0);
        checkOutput("midrst_wdata", {32'd0, rf_wdata},  64'd0);
        checkOutput("midrst_drop",  {48'd0, drop_cnt},  64'd0);
        rst = 1'b1;
        modelReset();
        runCycle("post_rst", 3'b001);
        @(negedge clk);
        req_valid = '0;
        runCycle("post_rst_idle", 3'b000);

        // Drop counter saturates instead of wrapping
        resetDut();
        @(negedge clk);
        applyStimulus(0, 1'b1, 5'd0, 32'h0000_0000, 1'b0, 1'b1);
        repeat (65540) @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        #1;
        checkOutput("sat_drop", {48'd0, drop_cnt}, 64'hFFFF);
        checkOutput("sat_we",   {63'd0, rf_we},    64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
